// File: rtl/rv32i_mem_arbiter_if.sv
// rtl/rv32i_mem_arbiter_if.sv - fetch, LSU and memory signal bundle for the I/D memory arbiter
// master: the core and memory side that drives requests and read data; slave: the arbiter.
interface rv32i_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdat;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdat;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdat;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdat;
    logic [31:0] mem_rdat;

    modport master (
        output i_req, i_addr,
        output d_req, d_we, d_addr, d_be, d_wdat,
        output mem_rdat,
        input  i_gnt, i_rvalid, i_rdat,
        input  d_gnt, d_rvalid, d_rdat,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdat
    );

    modport slave (
        input  i_req, i_addr,
        input  d_req, d_we, d_addr, d_be, d_wdat,
        input  mem_rdat,
        output i_gnt, i_rvalid, i_rdat,
        output d_gnt, d_rvalid, d_rdat,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdat
    );
endinterface

// File: rtl/rv32i_mem_arbiter.sv
// rtl/rv32i_mem_arbiter.sv - shares one fixed-latency memory between fetch (I) and LSU (D) ports
// Default: D priority with I starvation guard; define RV32I_ARB_RR_EN for round-robin.
module rv32i_mem_arbiter #(
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    rv32i_mem_arbiter_if.slave bus
);
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic sel_i;
    logic sel_d;
    logic arb_en;

    // Flopped reset release keeps grants low while reset is asserted without
    // routing the asynchronous reset into combinational logic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            arb_en <= 1'b0;
        end else begin
            arb_en <= 1'b1;
        end
    end

`ifdef RV32I_ARB_RR_EN
    logic last_gnt;

    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (arb_en) begin
            if (bus.i_req && bus.d_req) begin
                sel_d = (last_gnt == PORT_I);
                sel_i = !sel_d;
            end else begin
                sel_i = bus.i_req;
                sel_d = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_gnt <= PORT_I;
        end else if (sel_d) begin
            last_gnt <= PORT_D;
        end else if (sel_i) begin
            last_gnt <= PORT_I;
        end
    end
`else
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt;

    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        if (arb_en) begin
            if (bus.i_req && bus.d_req) begin
                sel_i = (starve_cnt == STARVE_LIM);
                sel_d = !sel_i;
            end else begin
                sel_i = bus.i_req;
                sel_d = bus.d_req;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= 4'd0;
        end else if (bus.i_req && !sel_i) begin
            if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end else begin
            starve_cnt <= 4'd0;
        end
    end
`endif

    assign bus.i_gnt = sel_i;
    assign bus.d_gnt = sel_d;

    always_comb begin
        bus.mem_req  = 1'b0;
        bus.mem_we   = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_be   = 4'h0;
        bus.mem_wdat = 32'h0;
        if (sel_d) begin
            bus.mem_req  = 1'b1;
            bus.mem_we   = bus.d_we;
            bus.mem_addr = bus.d_addr;
            bus.mem_be   = bus.d_be;
            bus.mem_wdat = bus.d_wdat;
        end else if (sel_i) begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = bus.i_addr;
            bus.mem_be   = 4'hF;
        end
    end

    // One stage per cycle of read latency; the tail lines up with mem_rdat.
    logic [RD_LAT-1:0] sr_valid;
    logic [RD_LAT-1:0] sr_port;
    logic [RD_LAT-1:0] sr_we;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_valid <= '0;
            sr_port  <= '0;
            sr_we    <= '0;
        end else begin
            for (int k = RD_LAT - 1; k > 0; k--) begin
                sr_valid[k] <= sr_valid[k-1];
                sr_port[k]  <= sr_port[k-1];
                sr_we[k]    <= sr_we[k-1];
            end
            sr_valid[0] <= sel_i | sel_d;
            sr_port[0]  <= sel_d ? PORT_D : PORT_I;
            sr_we[0]    <= sel_d & bus.d_we;
        end
    end

    logic tail_valid;
    logic tail_port;
    logic tail_we;

    assign tail_valid = sr_valid[RD_LAT-1];
    assign tail_port  = sr_port[RD_LAT-1];
    assign tail_we    = sr_we[RD_LAT-1];

    always_comb begin
        bus.i_rvalid = 1'b0;
        bus.i_rdat   = 32'h0;
        bus.d_rvalid = 1'b0;
        bus.d_rdat   = 32'h0;
        if (tail_valid && tail_port == PORT_I) begin
            bus.i_rvalid = 1'b1;
            bus.i_rdat   = bus.mem_rdat;
        end
        if (tail_valid && tail_port == PORT_D) begin
            bus.d_rvalid = 1'b1;
            if (!tail_we) begin
                bus.d_rdat = bus.mem_rdat;
            end
        end
    end

    a_legal_params: assert property (@(posedge clk_i)
        (RD_LAT >= 1) && (RD_LAT <= 4) && (STARVE_MAX >= 1) && (STARVE_MAX <= 15));

    a_i_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.i_gnt |-> (bus.i_addr[1:0] == 2'b00));
endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// tb/tb_rv32i_mem_arbiter.sv - randomized self-checking bench for rv32i_mem_arbiter (RD_LAT 1 and 3)
module tb_rv32i_mem_arbiter;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int SMAX  = 4;

    typedef struct {
        int          due;
        bit          port;
        bit          we;
        logic [31:0] data;
    } rsp_t;

    logic clk;
    logic rst_n;

    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdat;
    logic [31:0] rdat1;
    logic [31:0] rdat3;

    int pass_cnt;
    int total_cnt;
    int cyc;

    bit   i_pend;
    bit   d_pend;
    int   m_refused;
    bit   m_last;
    logic [31:0] mem_m [0:255];
    rsp_t q1[$];
    rsp_t q3[$];

    rv32i_mem_arbiter_if bus1 ();
    rv32i_mem_arbiter_if bus3 ();

    assign bus1.i_req    = i_req;
    assign bus1.i_addr   = i_addr;
    assign bus1.d_req    = d_req;
    assign bus1.d_we     = d_we;
    assign bus1.d_addr   = d_addr;
    assign bus1.d_be     = d_be;
    assign bus1.d_wdat   = d_wdat;
    assign bus1.mem_rdat = rdat1;

    assign bus3.i_req    = i_req;
    assign bus3.i_addr   = i_addr;
    assign bus3.d_req    = d_req;
    assign bus3.d_we     = d_we;
    assign bus3.d_addr   = d_addr;
    assign bus3.d_be     = d_be;
    assign bus3.d_wdat   = d_wdat;
    assign bus3.mem_rdat = rdat3;

    rv32i_mem_arbiter #(.RD_LAT(LAT_A), .STARVE_MAX(SMAX)) u_dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus1)
    );

    rv32i_mem_arbiter #(.RD_LAT(LAT_B), .STARVE_MAX(SMAX)) u_dut3 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One bus cycle: present requests, compare both DUTs against the reference, then commit.
    task automatic step(input bit wi, input logic [31:0] ia, input bit wd, input bit dwe,
                        input logic [31:0] da, input logic [3:0] dbe, input logic [31:0] dwd);
        bit gi, gd, has;
        rsp_t ent;
        logic o_ig, o_dg, o_mreq, o_mwe, o_iv, o_dv;
        logic [31:0] o_ma, o_mw, o_ir, o_dr, e_ir, e_dr, e_ma;
        logic [3:0] o_mb, e_mb;
        bit e_iv, e_dv;
        rsp_t ni;
        rsp_t nd;

        @(negedge clk);
        cyc++;
        if (!i_pend && wi) begin
            i_pend = 1'b1;
            i_addr = ia;
        end
        if (!d_pend && wd) begin
            d_pend = 1'b1;
            d_we   = dwe;
            d_addr = da;
            d_be   = dbe;
            d_wdat = dwd;
        end
        i_req = i_pend;
        d_req = d_pend;
        rdat1 = $urandom;
        if (q1.size() > 0 && q1[0].due == cyc && !q1[0].we) rdat1 = q1[0].data;
        rdat3 = $urandom;
        if (q3.size() > 0 && q3[0].due == cyc && !q3[0].we) rdat3 = q3[0].data;

        if (i_req && d_req) begin
`ifdef RV32I_ARB_RR_EN
            gd = (m_last == 1'b0);
`else
            gd = (m_refused < SMAX);
`endif
            gi = !gd;
        end else begin
            gi = i_req;
            gd = d_req;
        end
        e_mb = gd ? d_be : (gi ? 4'hF : 4'h0);
        e_ma = gd ? d_addr : i_addr;

        #1;
        for (int w = 0; w < 2; w++) begin
            if (w == 0) begin
                o_ig = bus1.i_gnt; o_dg = bus1.d_gnt; o_mreq = bus1.mem_req; o_mwe = bus1.mem_we;
                o_ma = bus1.mem_addr; o_mb = bus1.mem_be; o_mw = bus1.mem_wdat;
                o_iv = bus1.i_rvalid; o_ir = bus1.i_rdat; o_dv = bus1.d_rvalid; o_dr = bus1.d_rdat;
                has = (q1.size() > 0) && (q1[0].due == cyc);
                if (has) ent = q1[0];
            end else begin
                o_ig = bus3.i_gnt; o_dg = bus3.d_gnt; o_mreq = bus3.mem_req; o_mwe = bus3.mem_we;
                o_ma = bus3.mem_addr; o_mb = bus3.mem_be; o_mw = bus3.mem_wdat;
                o_iv = bus3.i_rvalid; o_ir = bus3.i_rdat; o_dv = bus3.d_rvalid; o_dr = bus3.d_rdat;
                has = (q3.size() > 0) && (q3[0].due == cyc);
                if (has) ent = q3[0];
            end
            e_iv = has && !ent.port;
            e_dv = has && ent.port;
            e_ir = e_iv ? ent.data : 32'h0;
            e_dr = (e_dv && !ent.we) ? ent.data : 32'h0;

            total_cnt++;
            if (o_ig !== gi || o_dg !== gd)
                $display("FAIL grant w%0d cyc %0d got i=%b d=%b want i=%b d=%b", w, cyc, o_ig, o_dg, gi, gd);
            else pass_cnt++;
            total_cnt++;
            if (o_mreq !== (gi | gd) || o_mwe !== (gd & d_we) || o_mb !== e_mb)
                $display("FAIL mem_ctl w%0d cyc %0d got req=%b we=%b be=%h want req=%b we=%b be=%h",
                         w, cyc, o_mreq, o_mwe, o_mb, gi | gd, gd & d_we, e_mb);
            else pass_cnt++;
            if (gi | gd) begin
                total_cnt++;
                if (o_ma !== e_ma || (gd && o_mw !== d_wdat))
                    $display("FAIL mem_payload w%0d cyc %0d got addr=%h wdat=%h want addr=%h wdat=%h",
                             w, cyc, o_ma, o_mw, e_ma, d_wdat);
                else pass_cnt++;
            end
            total_cnt++;
            if (o_iv !== e_iv || o_ir !== e_ir || o_dv !== e_dv || o_dr !== e_dr)
                $display("FAIL response w%0d cyc %0d got iv=%b ir=%h dv=%b dr=%h want iv=%b ir=%h dv=%b dr=%h",
                         w, cyc, o_iv, o_ir, o_dv, o_dr, e_iv, e_ir, e_dv, e_dr);
            else pass_cnt++;
        end

        if (q1.size() > 0 && q1[0].due == cyc) void'(q1.pop_front());
        if (q3.size() > 0 && q3[0].due == cyc) void'(q3.pop_front());
        if (gi) begin
            ni = '{due: 0, port: 1'b0, we: 1'b0, data: mem_m[i_addr[9:2]]};
            ni.due = cyc + LAT_A; q1.push_back(ni);
            ni.due = cyc + LAT_B; q3.push_back(ni);
            i_pend = 1'b0;
            m_last = 1'b0;
        end
        if (gd) begin
            nd = '{due: 0, port: 1'b1, we: d_we, data: d_we ? 32'h0 : mem_m[d_addr[9:2]]};
            if (d_we) begin
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) mem_m[d_addr[9:2]][8*b +: 8] = d_wdat[8*b +: 8];
            end
            nd.due = cyc + LAT_A; q1.push_back(nd);
            nd.due = cyc + LAT_B; q3.push_back(nd);
            d_pend = 1'b0;
            m_last = 1'b1;
        end
        if (i_req && !gi) m_refused = (m_refused < SMAX) ? m_refused + 1 : m_refused;
        else m_refused = 0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    // Hold reset with both ports requesting; every DUT output must stay 0.
    task automatic do_reset();
        logic [137:0] o1, o3;
        @(negedge clk);
        rst_n = 1'b0;
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 32'h40; d_addr = 32'h80; d_be = 4'hF; d_wdat = 32'hFFFF_FFFF;
        rdat1 = 32'hFFFF_FFFF; rdat3 = 32'hFFFF_FFFF;
        for (int k = 0; k < 3; k++) begin
            #1;
            o1 = {bus1.i_gnt, bus1.i_rvalid, bus1.i_rdat, bus1.d_gnt, bus1.d_rvalid, bus1.d_rdat,
                  bus1.mem_req, bus1.mem_we, bus1.mem_addr, bus1.mem_be, bus1.mem_wdat};
            o3 = {bus3.i_gnt, bus3.i_rvalid, bus3.i_rdat, bus3.d_gnt, bus3.d_rvalid, bus3.d_rdat,
                  bus3.mem_req, bus3.mem_we, bus3.mem_addr, bus3.mem_be, bus3.mem_wdat};
            total_cnt++;
            if (o1 !== '0 || o3 !== '0) $display("FAIL reset_outputs got %h / %h want 0", o1, o3);
            else pass_cnt++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        i_req = 1'b0; d_req = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0;
        m_refused = 0; m_last = 1'b0;
        q1.delete(); q3.delete();
    endtask

    task automatic test_reset();
        do_reset();
        idle(10);
    endtask

    task automatic test_i_fetch();
        mem_m[8'h40] = 32'hDEAD_BEEF;
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        total_cnt++;
        if (bus1.i_gnt !== 1'b1 || bus1.mem_be !== 4'hF || bus1.mem_addr !== 32'h100)
            $display("FAIL i_fetch_issue got gnt=%b be=%h addr=%h want 1 f 00000100",
                     bus1.i_gnt, bus1.mem_be, bus1.mem_addr);
        else pass_cnt++;
        idle(1);
        total_cnt++;
        if (bus1.i_rvalid !== 1'b1 || bus1.i_rdat !== 32'hDEAD_BEEF)
            $display("FAIL i_fetch_lat1 got v=%b d=%h want 1 deadbeef", bus1.i_rvalid, bus1.i_rdat);
        else pass_cnt++;
        idle(2);
        total_cnt++;
        if (bus3.i_rvalid !== 1'b1 || bus3.i_rdat !== 32'hDEAD_BEEF)
            $display("FAIL i_fetch_lat3 got v=%b d=%h want 1 deadbeef", bus3.i_rvalid, bus3.i_rdat);
        else pass_cnt++;
        idle(2);
    endtask

    task automatic test_d_write_read();
        mem_m[8'h81] = 32'h0;
        step(1'b0, 32'h0, 1'b1, 1'b1, 32'h204, 4'b0100, 32'h00AB_0000);
        total_cnt++;
        if (bus1.mem_we !== 1'b1 || bus1.mem_be !== 4'b0100 || bus1.mem_wdat !== 32'h00AB_0000)
            $display("FAIL d_store_issue got we=%b be=%h wdat=%h want 1 4 00ab0000",
                     bus1.mem_we, bus1.mem_be, bus1.mem_wdat);
        else pass_cnt++;
        idle(1);
        total_cnt++;
        if (bus1.d_rvalid !== 1'b1 || bus1.d_rdat !== 32'h0)
            $display("FAIL d_store_rsp got v=%b d=%h want 1 0", bus1.d_rvalid, bus1.d_rdat);
        else pass_cnt++;
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h204, 4'hF, 32'h0);
        idle(1);
        total_cnt++;
        if (bus1.d_rvalid !== 1'b1 || bus1.d_rdat !== 32'h00AB_0000)
            $display("FAIL d_load_rsp got v=%b d=%h want 1 00ab0000", bus1.d_rvalid, bus1.d_rdat);
        else pass_cnt++;
        idle(3);
    endtask

    task automatic test_contention();
        logic [9:0] pat;
`ifdef RV32I_ARB_RR_EN
        pat = 10'b0101010101;
`else
        pat = 10'b0111101111;
`endif
        do_reset();
        for (int k = 0; k < 10; k++) begin
            step(1'b1, {22'h0, 8'($urandom), 2'b00}, 1'b1, 1'($urandom_range(0, 1)),
                 {22'h0, 8'($urandom), 2'b00}, 4'($urandom_range(1, 15)), $urandom);
            total_cnt++;
            if (bus1.d_gnt !== pat[k] || bus1.i_gnt !== !pat[k] || bus3.d_gnt !== pat[k])
                $display("FAIL contention_pattern k=%0d got d=%b i=%b want d=%b", k, bus1.d_gnt,
                         bus1.i_gnt, pat[k]);
            else pass_cnt++;
        end
        idle(5);
    endtask

    task automatic test_pipelined();
        logic [31:0] ev [4];
        logic [3:0]  vv;
        mem_m[0] = 32'h1111_0000;
        mem_m[1] = 32'h2222_0004;
        mem_m[2] = 32'h3333_0008;
        ev[0] = mem_m[0]; ev[1] = mem_m[1]; ev[2] = mem_m[2]; ev[3] = 32'h0;
        vv = 4'b0111;
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        for (int j = 0; j < 4; j++) begin
            idle(1);
            total_cnt++;
            if (bus3.d_rvalid !== vv[j] || bus3.d_rdat !== ev[j])
                $display("FAIL pipelined_lat3 j=%0d got v=%b d=%h want v=%b d=%h", j, bus3.d_rvalid,
                         bus3.d_rdat, vv[j], ev[j]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 1)), {22'h0, 8'($urandom), 2'b00},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 {22'h0, 8'($urandom), 2'b00}, 4'($urandom_range(1, 15)), $urandom);
        end
        idle(5);
    endtask

    // Reset while reads are in flight; no response may surface afterwards.
    task automatic test_reset_midflight();
        step(1'b1, 32'h10, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        #1;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus1.i_rvalid !== 1'b0 || bus1.d_rvalid !== 1'b0 || bus3.i_rvalid !== 1'b0 ||
            bus3.d_rvalid !== 1'b0 || bus1.i_gnt !== 1'b0 || bus3.mem_req !== 1'b0)
            $display("FAIL midflight_reset got iv=%b dv=%b iv3=%b dv3=%b want 0", bus1.i_rvalid,
                     bus1.d_rvalid, bus3.i_rvalid, bus3.d_rvalid);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        i_req = 1'b0; d_req = 1'b0;
        i_pend = 1'b0; d_pend = 1'b0;
        m_refused = 0; m_last = 1'b0;
        q1.delete(); q3.delete();
        idle(6);
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0; cyc = 0;
        i_pend = 1'b0; d_pend = 1'b0; m_refused = 0; m_last = 1'b0;
        rst_n = 1'b0;
        i_req = 1'b0; i_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_be = 4'h0; d_wdat = 32'h0;
        rdat1 = 32'h0; rdat3 = 32'h0;
        for (int k = 0; k < 256; k++) mem_m[k] = $urandom;

        test_reset();
        test_i_fetch();
        test_d_write_read();
        test_contention();
        test_pipelined();
        test_random();
        test_reset_midflight();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
